// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package fetch_stage_pkg;

   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;

   localparam word_t ZERO      = '0;
   localparam word_t INSTR_NOP = ZERO;
   localparam word_t PC_STEP   = 32'd4;

   typedef enum logic [1:0] {
      FS_FETCH = 2'd0,
      FS_DRAIN = 2'd1,
      FS_HOLD  = 2'd2
   } fetch_state_e;

   // Selects what the IF/ID-facing output registers load on the next edge.
   typedef enum logic [1:0] {
      OUT_KEEP   = 2'd0,
      OUT_BUBBLE = 2'd1,
      OUT_MEM    = 2'd2,
      OUT_HELD   = 2'd3
   } out_sel_e;

   function automatic word_t word_align(input word_t addr);
      return addr & ~word_t'(3);
   endfunction

   function automatic word_t pc_plus4(input word_t addr);
      return addr + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter and drain-address registers for the fetch stage.
// Load (redirect) takes priority over increment; addresses are always word-aligned.
module fetch_pc_reg
   import fetch_stage_pkg::*;
#(
   parameter word_t RESET_PC = 32'h0000_0000
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  load,
   input  word_t load_addr,
   input  logic  inc,
   input  logic  capture_drain,
   output word_t pc,
   output word_t drain_addr
);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= word_align(RESET_PC);
         drain_addr <= ZERO;
      end else begin
         if (load) begin
            pc <= word_align(load_addr);
         end else if (inc) begin
            pc <= pc_plus4(pc);
         end
         // Remember the address of the request still in flight at redirect time.
         if (capture_drain) begin
            drain_addr <= pc;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake, stall/redirect handling, NOP bubbles.
// Optional FETCH_ALIGN_CHECK_EN adds misalign_if, pulsed for a redirect to a non-word address.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter word_t RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         redirect,
   input  word_t        redirect_pc,
   // imem handshake: a request stays up with imem_addr stable until the cycle
   // imem_ack is high; imem_rdata is valid in that same cycle and the transfer
   // completes on that edge. Dropping imem_req without ack (reset) abandons it.
   output logic         imem_req,
   output word_t        imem_addr,
   input  logic         imem_ack,
   input  word_t        imem_rdata,
   output word_t        nPC_if,
   output word_t        IR_if,
   output logic         valid_if,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic         misalign_if,
`endif
   output fetch_state_e state_dbg
);

   fetch_state_e state, next_state;
   out_sel_e     out_sel;
   logic         pc_load, pc_inc, drain_cap, hold_cap;
   word_t        pc, drain_addr;
   word_t        hold_ir, hold_npc;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk           (clk),
      .reset         (reset),
      .load          (pc_load),
      .load_addr     (redirect_pc),
      .inc           (pc_inc),
      .capture_drain (drain_cap),
      .pc            (pc),
      .drain_addr    (drain_addr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FS_FETCH;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      out_sel    = OUT_KEEP;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      drain_cap  = 1'b0;
      hold_cap   = 1'b0;
      unique case (state)
         FS_FETCH: begin
            if (redirect) begin
               pc_load = 1'b1;
               out_sel = OUT_BUBBLE;
               if (!imem_ack) begin
                  drain_cap  = 1'b1;
                  next_state = FS_DRAIN;
               end
            end else if (imem_ack) begin
               pc_inc = 1'b1;
               if (stall) begin
                  hold_cap   = 1'b1;
                  next_state = FS_HOLD;
               end else begin
                  out_sel = OUT_MEM;
               end
            end else if (!stall) begin
               out_sel = OUT_BUBBLE;
            end
         end
         FS_DRAIN: begin
            out_sel = OUT_BUBBLE;
            pc_load = redirect;
            if (imem_ack) begin
               next_state = FS_FETCH;
            end
         end
         FS_HOLD: begin
            if (redirect) begin
               pc_load    = 1'b1;
               out_sel    = OUT_BUBBLE;
               next_state = FS_FETCH;
            end else if (!stall) begin
               out_sel    = OUT_HELD;
               next_state = FS_FETCH;
            end
         end
         default: begin
            next_state = FS_FETCH;
         end
      endcase
   end

   assign imem_req  = !reset && (state != FS_HOLD);
   assign imem_addr = (state == FS_DRAIN) ? drain_addr : pc;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         IR_if    <= ZERO;
         nPC_if   <= ZERO;
         valid_if <= 1'b0;
         hold_ir  <= ZERO;
         hold_npc <= ZERO;
      end else begin
         if (hold_cap) begin
            hold_ir  <= imem_rdata;
            hold_npc <= pc_plus4(pc);
         end
         unique case (out_sel)
            OUT_BUBBLE: begin
               IR_if    <= INSTR_NOP;
               valid_if <= 1'b0;
            end
            OUT_MEM: begin
               IR_if    <= imem_rdata;
               nPC_if   <= pc_plus4(pc);
               valid_if <= 1'b1;
            end
            OUT_HELD: begin
               IR_if    <= hold_ir;
               nPC_if   <= hold_npc;
               valid_if <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_if <= 1'b0;
      end else begin
         misalign_if <= redirect && (redirect_pc[1:0] != 2'b00);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (RESET_PC = 0x40).
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         stall = 1'b0;
   logic         redirect = 1'b0;
   word_t        redirect_pc = '0;
   logic         imem_req;
   word_t        imem_addr;
   logic         imem_ack = 1'b0;
   word_t        imem_rdata = '0;
   word_t        nPC_if;
   word_t        IR_if;
   logic         valid_if;
   fetch_state_e state_dbg;
`ifdef FETCH_ALIGN_CHECK_EN
   logic         misalign_if;
`endif

   int checks = 0;
   int errors = 0;

   fetch_stage #(.RESET_PC(32'h0000_0040)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .nPC_if      (nPC_if),
      .IR_if       (IR_if),
      .valid_if    (valid_if),
`ifdef FETCH_ALIGN_CHECK_EN
      .misalign_if (misalign_if),
`endif
      .state_dbg   (state_dbg)
   );

   // Clock and reset block
   always #5 clk = ~clk;

   // Driver tasks: inputs change 1ns after the rising edge, checks happen there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic rd, input word_t rpc,
                        input logic ack, input word_t rdata);
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      imem_ack    = ack;
      imem_rdata  = rdata;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   // Redirect with a simultaneous ack: stays in FETCH, pc = target.
   task automatic jump_to(input word_t target);
      drive(1'b0, 1'b1, target, 1'b1, 32'hDEAD_DEAD);
      step();
      idle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      step();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", imem_req); end
      checks++; if (IR_if !== 32'h0) begin errors++; $display("FAIL reset_ir got %h exp 00000000", IR_if); end
      checks++; if (nPC_if !== 32'h0) begin errors++; $display("FAIL reset_npc got %h exp 00000000", nPC_if); end
      checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid_if); end
      checks++; if (state_dbg !== FS_FETCH) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
`ifdef FETCH_ALIGN_CHECK_EN
      checks++; if (misalign_if !== 1'b0) begin errors++; $display("FAIL reset_misalign got %0b exp 0", misalign_if); end
`endif
      reset = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req got %0b exp 1", imem_req); end
      checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL post_reset_addr got %h exp 00000040", imem_addr); end
   endtask

   task automatic test_zero_wait();
      word_t exp_npc [3] = '{32'h44, 32'h48, 32'h4C};
      word_t exp_addr[3] = '{32'h44, 32'h48, 32'h4C};
      word_t data    [3] = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, '0, 1'b1, data[i]);
         step();
         checks++; if (IR_if !== data[i]) begin errors++; $display("FAIL zw_ir[%0d] got %h exp %h", i, IR_if, data[i]); end
         checks++; if (nPC_if !== exp_npc[i]) begin errors++; $display("FAIL zw_npc[%0d] got %h exp %h", i, nPC_if, exp_npc[i]); end
         checks++; if (valid_if !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d] got %0b exp 1", i, valid_if); end
         checks++; if (imem_addr !== exp_addr[i]) begin errors++; $display("FAIL zw_addr[%0d] got %h exp %h", i, imem_addr, exp_addr[i]); end
      end
      idle();
   endtask

   task automatic test_wait_states();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL ws_addr[%0d] got %h exp 00000040", i, imem_addr); end
         step();
         checks++; if (IR_if !== 32'h0) begin errors++; $display("FAIL ws_bubble_ir[%0d] got %h exp 00000000", i, IR_if); end
         checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL ws_bubble_valid[%0d] got %0b exp 0", i, valid_if); end
      end
      checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL ws_addr[2] got %h exp 00000040", imem_addr); end
      drive(1'b0, 1'b0, '0, 1'b1, 32'h0000_0033);
      step();
      checks++; if (IR_if !== 32'h33) begin errors++; $display("FAIL ws_ir got %h exp 00000033", IR_if); end
      checks++; if (nPC_if !== 32'h44) begin errors++; $display("FAIL ws_npc got %h exp 00000044", nPC_if); end
      checks++; if (valid_if !== 1'b1) begin errors++; $display("FAIL ws_valid got %0b exp 1", valid_if); end
      idle();
   endtask

   task automatic test_stall_hold();
      jump_to(32'h10);
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL sh_addr got %h exp 00000010", imem_addr); end
      checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL sh_redirect_valid got %0b exp 0", valid_if); end
      drive(1'b1, 1'b0, '0, 1'b1, 32'h8C00_0004);
      step();
      checks++; if (state_dbg !== FS_HOLD) begin errors++; $display("FAIL sh_state got %0d exp 2", state_dbg); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sh_req got %0b exp 0", imem_req); end
      checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL sh_frozen_valid got %0b exp 0", valid_if); end
      checks++; if (nPC_if !== 32'h44) begin errors++; $display("FAIL sh_frozen_npc got %h exp 00000044", nPC_if); end
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      step();
      checks++; if (state_dbg !== FS_HOLD) begin errors++; $display("FAIL sh_state2 got %0d exp 2", state_dbg); end
      idle();
      step();
      checks++; if (IR_if !== 32'h8C00_0004) begin errors++; $display("FAIL sh_ir got %h exp 8c000004", IR_if); end
      checks++; if (nPC_if !== 32'h14) begin errors++; $display("FAIL sh_npc got %h exp 00000014", nPC_if); end
      checks++; if (valid_if !== 1'b1) begin errors++; $display("FAIL sh_valid got %0b exp 1", valid_if); end
      checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL sh_next_addr got %h exp 00000014", imem_addr); end
   endtask

   task automatic test_redirect_drain();
      jump_to(32'h20);
      drive(1'b0, 1'b1, 32'h200, 1'b0, '0);
      step();
      checks++; if (state_dbg !== FS_DRAIN) begin errors++; $display("FAIL rd_state got %0d exp 1", state_dbg); end
      checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL rd_addr0 got %h exp 00000020", imem_addr); end
      checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL rd_valid0 got %0b exp 0", valid_if); end
      idle();
      step();
      checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL rd_addr1 got %h exp 00000020", imem_addr); end
      drive(1'b0, 1'b0, '0, 1'b1, 32'h0000_0BAD);
      step();
      checks++; if (IR_if !== 32'h0) begin errors++; $display("FAIL rd_dropped_ir got %h exp 00000000", IR_if); end
      checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL rd_dropped_valid got %0b exp 0", valid_if); end
      checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rd_target_addr got %h exp 00000200", imem_addr); end
      drive(1'b0, 1'b0, '0, 1'b1, 32'h0000_0055);
      step();
      checks++; if (IR_if !== 32'h55) begin errors++; $display("FAIL rd_ir got %h exp 00000055", IR_if); end
      checks++; if (nPC_if !== 32'h204) begin errors++; $display("FAIL rd_npc got %h exp 00000204", nPC_if); end
      idle();
   endtask

   task automatic test_redirect_in_hold();
      drive(1'b1, 1'b0, '0, 1'b1, 32'h0000_0066);
      step();
      checks++; if (state_dbg !== FS_HOLD) begin errors++; $display("FAIL rh_state got %0d exp 2", state_dbg); end
      drive(1'b1, 1'b1, 32'h200, 1'b0, '0);
      step();
      checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL rh_valid got %0b exp 0", valid_if); end
      checks++; if (IR_if !== 32'h0) begin errors++; $display("FAIL rh_ir got %h exp 00000000", IR_if); end
      checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rh_addr got %h exp 00000200", imem_addr); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rh_req got %0b exp 1", imem_req); end
      idle();
   endtask

   task automatic test_wrap();
      jump_to(32'hFFFF_FFFC);
      drive(1'b0, 1'b0, '0, 1'b1, 32'h0000_0077);
      step();
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 00000000", imem_addr); end
      checks++; if (nPC_if !== 32'h0) begin errors++; $display("FAIL wrap_npc got %h exp 00000000", nPC_if); end
      checks++; if (IR_if !== 32'h77) begin errors++; $display("FAIL wrap_ir got %h exp 00000077", IR_if); end
      idle();
   endtask

   task automatic test_unaligned();
      drive(1'b0, 1'b1, 32'h202, 1'b1, 32'hDEAD_DEAD);
      step();
      checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL ua_addr got %h exp 00000200", imem_addr); end
`ifdef FETCH_ALIGN_CHECK_EN
      checks++; if (misalign_if !== 1'b1) begin errors++; $display("FAIL ua_misalign got %0b exp 1", misalign_if); end
`endif
      idle();
      step();
`ifdef FETCH_ALIGN_CHECK_EN
      checks++; if (misalign_if !== 1'b0) begin errors++; $display("FAIL ua_misalign_pulse got %0b exp 0", misalign_if); end
`endif
      checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL ua_addr_hold got %h exp 00000200", imem_addr); end
   endtask

   task automatic test_reset_mid();
      jump_to(32'h80);
      reset = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req got %0b exp 0", imem_req); end
      step();
      reset = 1'b0;
      #1;
      checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL rm_addr got %h exp 00000040", imem_addr); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_req_after got %0b exp 1", imem_req); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall_hold();
      test_redirect_drain();
      test_redirect_in_hold();
      test_wrap();
      test_unaligned();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
